// File: rtl/gate_response_checker.sv
// gate_response_checker
//   Reading end of the gate vector-driver flow. Accepts an (a,b) vector on
//   vec_valid, waits SETTLE_CYC cycles, samples y and compares it against the
//   truth table of the gate selected by gate_sel. Keeps a saturating error
//   count, the most recent failing {a,b,y}, and which of the four input
//   combinations have been compared. Reports done/pass once all four are seen.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   IDLE    | after reset, waiting for start
//   ARMED   | vec_ready=1, waiting for vec_valid
//   SETTLE  | counting down the settle window, samples y at zero
//   COMPARE | one cycle: update err_cnt / cov_mask / last_fail
//   DONE    | all four combos seen, done=1, pass valid
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start           clear stats and arm (priority over vec_valid)
//   gate_sel[2:0]   0 AND,1 OR,2 NAND,3 NOR,4 XOR,5 XNOR,6/7 always error
//   vec_valid,a,b   vector strobe and gate inputs
//   y               gate output under check
//   vec_ready,busy,done,pass       status
//   err_cnt,cov_mask,last_fail     statistics
module gate_response_checker #(
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       gate_sel,
    input  logic             vec_valid,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             vec_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov_mask,
    output logic [2:0]       last_fail
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        SETTLE  = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Loading SETTLE_CYC-1 makes y land in y_q exactly SETTLE_CYC edges
    // after the acceptance edge.
    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};

    state_t           state, state_nx;
    logic [7:0]       settle_cnt;
    logic             a_q, b_q, y_q;
    logic [2:0]       sel_q;
    logic             exp_y;
    logic             mism;
    logic [CNT_W-1:0] err_upd;
    logic [3:0]       cov_upd;

    always_comb begin
        exp_y = 1'b0;
        case (sel_q)
            3'd0:    exp_y = a_q & b_q;
            3'd1:    exp_y = a_q | b_q;
            3'd2:    exp_y = ~(a_q & b_q);
            3'd3:    exp_y = ~(a_q | b_q);
            3'd4:    exp_y = a_q ^ b_q;
            3'd5:    exp_y = ~(a_q ^ b_q);
            default: exp_y = 1'b0;
        endcase
    end

    // Reserved selects have no truth table, so every compare counts as an error.
    assign mism    = (sel_q[2:1] == 2'b11) || (y_q != exp_y);
    assign err_upd = (mism && (err_cnt != ERR_MAX)) ? err_cnt + CNT_W'(1) : err_cnt;
    assign cov_upd = cov_mask | (4'b0001 << {a_q, b_q});

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = ARMED;
        end else begin
            case (state)
                IDLE:    state_nx = IDLE;
                ARMED:   if (vec_valid) state_nx = SETTLE;
                SETTLE:  if (settle_cnt == 8'd0) state_nx = COMPARE;
                COMPARE: state_nx = (cov_upd == 4'hF) ? DONE : ARMED;
                DONE:    state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        vec_ready = (state == ARMED);
        busy      = (state == SETTLE) || (state == COMPARE);
        done      = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= 8'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            y_q        <= 1'b0;
            sel_q      <= 3'd0;
            err_cnt    <= '0;
            cov_mask   <= 4'h0;
            last_fail  <= 3'b000;
            pass       <= 1'b0;
        end else if (start) begin
            err_cnt   <= '0;
            cov_mask  <= 4'h0;
            last_fail <= 3'b000;
            pass      <= 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (vec_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        sel_q      <= gate_sel;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0) y_q <= y;
                    else                    settle_cnt <= settle_cnt - 8'd1;
                end
                COMPARE: begin
                    err_cnt  <= err_upd;
                    cov_mask <= cov_upd;
                    if (mism) last_fail <= {a_q, b_q, y_q};
                    // Only true when this compare completes coverage, i.e. on
                    // entry to DONE; stays 0 on the way back to ARMED.
                    pass <= (cov_upd == 4'hF) && (err_upd == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
